hilo_div_unit: RTL
==================

Name: hilo_div_unit

Overview:
- Iterative radix-2 restoring divider for the DIV/DIVU instructions, in the execute stage downstream of the main/ALU decoders.
- Takes the decoded divide request and both register operands, and runs one quotient bit per clock.
- Holds the pipeline stall until done, then presents {remainder, quotient} for the HI/LO write (hilowrite path).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  divide request from execute stage; held high until ready seen.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- annul  input  1  flush/cancel request (exception or branch kill).
- opdata1  input  WIDTH  dividend (rs); sampled when start accepted.
- opdata2  input  WIDTH  divisor (rt); sampled when start accepted.
- result  output  2*WIDTH  {remainder[2W-1:W] -> HI, quotient[W-1:0] -> LO}.
- ready  output  1  result valid; registered.
- stall  output  1  pipeline stall request; combinational, equals start & ~ready.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, ready=0, result=0, internal registers=0. Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE, DIVZERO, ON, END.
- IDLE, start=1 and annul=0 (accept edge):
  - Latch signed_div and the operand signs.
  - If signed_div, latch operand magnitudes, where |x| = ~x+1 for x negative; otherwise latch raw operands.
  - If opdata2==0, go to DIVZERO; else go to ON with count=0 and partial remainder=0.
- IDLE, start=0 or annul=1: stay in IDLE; ready=0.
- ON, one step per clock:
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem = trial and the quotient bit is 1; else the quotient bit is 0.
  - count increments each step.
  - After the step with count==WIDTH-1, go to END and load result.
  - ON therefore occupies exactly WIDTH cycles.
- Sign correction (signed_div=1), applied when loading result:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative, so its sign follows the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient wraps to 0x80000000, remainder 0. No trap.
- DIVZERO: single cycle; result=0 (HI=0, LO=0); go to END.
- END: ready=1 and result is stable.
  - Stay in END while start=1.
  - When start=0, go to IDLE with ready=0 on that edge; result holds its value.
- Latency:
  - Normal divide: ready rises WIDTH+1 clocks after the accept edge (33 for WIDTH=32).
  - Divide by zero: ready rises 2 clocks after the accept edge.
- annul in DIVZERO or ON: go to IDLE next edge with count=0, ready never asserted, result unchanged from its previous value.
- annul in END: go to IDLE; ready falls.
- start held high after END→IDLE (start dropped then reasserted) is a new request. Back-to-back requests need one IDLE cycle minimum.
- Operand changes while not in IDLE are ignored.
- result changes only on the edge entering END, or on reset.

Test Plan:
- DIVU: opdata1=100, opdata2=7, start held → ready high exactly 33 clocks after accept; result={32'd2, 32'd14}; stall high until ready, then low.
- DIV signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 → q=0xFFFFFFFD, r=1.
- Divide by zero: opdata1=0x1234, opdata2=0 → ready after 2 clocks; result=64'h0.
- Signed overflow: opdata1=0x80000000, opdata2=0xFFFFFFFF, DIV → result={32'h0, 32'h80000000}. The same operands with DIVU → q=0, r=0x80000000.
- annul asserted 10 cycles into ON → IDLE next edge; ready stays 0 for 40 further cycles; result unchanged. A new start on the following cycle completes normally in 33 clocks.
- Handshake and reset:
  - Hold start high 5 cycles past ready → ready stays 1 and result is stable; drop start → ready falls on the next edge.
  - Separately, pull rst low asynchronously mid-ON → ready=0 and result=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider for DIV/DIVU, producing {remainder, quotient} for HI/LO.
// Latency: ready rises WIDTH+1 clocks after the accept edge, or 2 clocks after it for a zero divisor.
// Backpressure: stall = start & ~ready holds the pipeline; ready and result stay up while start is held.
// Ports: clk, rst (async active-low), start/signed_div/annul control, opdata1 (dividend), opdata2 (divisor),
//        result {HI, LO}, ready (registered), stall (combinational).
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dvd;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic             sgn;
  logic             neg1;
  logic             neg2;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign stall = start & ~ready;

  always_comb begin
    mag1 = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + ONE) : opdata1;
    mag2 = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + ONE) : opdata2;

    // The shifted remainder needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1)
    // the doubled remainder can exceed WIDTH bits before the subtract.
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {dvd[WIDTH-2:0], ~trial[WIDTH]};

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    // The most-negative / -1 case falls out naturally: the magnitude quotient
    // 2^(WIDTH-1) negates to itself.
    q_fix = (sgn && (neg1 ^ neg2)) ? (~quo_nxt + ONE) : quo_nxt;
    r_fix = (sgn && neg1)          ? (~rem_nxt + ONE) : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      sgn    <= 1'b0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            sgn   <= signed_div;
            neg1  <= opdata1[WIDTH-1];
            neg2  <= opdata2[WIDTH-1];
            dvd   <= mag1;
            dvs   <= mag2;
            rem   <= '0;
            count <= '0;
            state <= (opdata2 == '0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          if (annul) begin
            count <= '0;
            state <= IDLE;
          end else begin
            result <= '0;
            state  <= END;
          end
        end
        ON: begin
          if (annul) begin
            count <= '0;
            state <= IDLE;
          end else begin
            rem   <= rem_nxt;
            dvd   <= quo_nxt;
            count <= count + CNT_ONE;
            if (count == CNT_LAST) begin
              result <= {r_fix, q_fix};
              count  <= '0;
              state  <= END;
            end
          end
        end
        END: begin
          // ready rises on the first edge spent in END, one clock after result loads.
          if (start && !annul) begin
            ready <= 1'b1;
          end else begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
